// File: rtl/lcd_text_driver.sv
// -----------------------------------------------------------------------------
// lcd_text_driver
//
// Consumer end of the LCD text character stream. After reset it runs the
// HD44780-style power-on initialisation. It then refreshes a 2x16 display
// forever in this order: line-1 address, 16 characters, line-2 address,
// 16 characters.
//
// Every LCD bus transaction takes one slot of SLOT_CYCLES clocks. lcd_e_o
// is high for E_WIDTH clocks starting at slot cycle E_ON. Data and RS are
// set up before E rises and are held until the slot ends.
//
// Ports
//   clk_i         system clock
//   resetn_i      synchronous active-low reset
//   char_data_i   character byte from the text source
//   char_valid_i  char_data_i valid this cycle
//   char_req_o    one-cycle pulse at slot start: next character wanted
//   line_sel_o    line of the requested character (0 = line 1)
//   char_idx_o    column 0..15 of the requested character
//   lcd_e_o       LCD enable strobe
//   lcd_rs_o      0 = command, 1 = data
//   lcd_rw_o      always 0 (write only)
//   lcd_data_o    LCD data bus
//   init_done_o   set on first entry to L1_ADDR, cleared only by reset
//   underrun_o    sticky: a character slot received no valid byte in time
//
// Build option
//   LCD_CURSOR_BLINK_EN  when defined, DISP_ON sends 0x0F
//                        (display, cursor and blink on) instead of 0x0C.
//
// state     | meaning
// ----------+-----------------------------------------------
// PWR_DELAY | idle POWERON_SLOTS slots after reset
// FUNC_SET  | command 0x38 (8-bit bus, 2 lines, 5x8 font)
// DISP_ON   | command 0x0C / 0x0F
// ENTRY     | command 0x06 (increment, no shift)
// CLEAR     | command 0x01 (clear display)
// CLR_WAIT  | idle CLEAR_SLOTS slots while the clear completes
// L1_ADDR   | command 0x80 (DDRAM address of line 1)
// L1_CHAR   | 16 data slots for line 1
// L2_ADDR   | command 0xC0 (DDRAM address of line 2)
// L2_CHAR   | 16 data slots for line 2
// -----------------------------------------------------------------------------
module lcd_text_driver #(
    parameter int SLOT_CYCLES   = 50,
    parameter int E_ON          = 10,
    parameter int E_WIDTH       = 20,
    parameter int POWERON_SLOTS = 70,
    parameter int CLEAR_SLOTS   = 40
) (
    input  logic       clk_i,
    input  logic       resetn_i,
    input  logic [7:0] char_data_i,
    input  logic       char_valid_i,
    output logic       char_req_o,
    output logic       line_sel_o,
    output logic [3:0] char_idx_o,
    output logic       lcd_e_o,
    output logic       lcd_rs_o,
    output logic       lcd_rw_o,
    output logic [7:0] lcd_data_o,
    output logic       init_done_o,
    output logic       underrun_o
);

    localparam int SC_W     = $clog2(SLOT_CYCLES);
    localparam int MAX_IDLE = (POWERON_SLOTS > CLEAR_SLOTS) ? POWERON_SLOTS : CLEAR_SLOTS;
    localparam int SL_W     = $clog2(MAX_IDLE + 1);

    localparam logic [SC_W-1:0] SC_LAST      = SC_W'(SLOT_CYCLES - 1);
    localparam logic [SC_W-1:0] SC_PRE       = SC_W'(E_ON - 2);
    localparam logic [SC_W-1:0] SC_LATCH_END = SC_W'(E_ON - 1);
    localparam logic [SC_W-1:0] SC_E_ON      = SC_W'(E_ON);
    localparam logic [SC_W-1:0] SC_E_OFF     = SC_W'(E_ON + E_WIDTH - 1);
    localparam logic [SL_W-1:0] PWR_LAST     = SL_W'(POWERON_SLOTS - 1);
    localparam logic [SL_W-1:0] CLR_LAST     = SL_W'(CLEAR_SLOTS - 1);

`ifdef LCD_CURSOR_BLINK_EN
    localparam logic [7:0] CMD_DISP_ON = 8'h0F;
`else
    localparam logic [7:0] CMD_DISP_ON = 8'h0C;
`endif

    typedef enum logic [3:0] {
        PWR_DELAY,
        FUNC_SET,
        DISP_ON,
        ENTRY,
        CLEAR,
        CLR_WAIT,
        L1_ADDR,
        L1_CHAR,
        L2_ADDR,
        L2_CHAR
    } state_t;

    state_t          state_q, state_d;
    logic [SC_W-1:0] sc_q, sc_d;
    logic [SL_W-1:0] slot_cnt_q, slot_cnt_d;
    logic [3:0]      char_idx_q, char_idx_d;
    logic            line_sel_q, line_sel_d;
    logic [7:0]      data_q, data_d;
    logic            got_q, got_d;
    logic            underrun_q, underrun_d;
    logic            init_done_q, init_done_d;

    logic            slot_end;
    logic            is_char;
    logic            is_idle;
    logic [7:0]      cmd_byte;

    always_ff @(posedge clk_i) begin
        if (!resetn_i) begin
            state_q     <= PWR_DELAY;
            sc_q        <= '0;
            slot_cnt_q  <= '0;
            char_idx_q  <= '0;
            line_sel_q  <= 1'b0;
            data_q      <= 8'h00;
            got_q       <= 1'b0;
            underrun_q  <= 1'b0;
            init_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            sc_q        <= sc_d;
            slot_cnt_q  <= slot_cnt_d;
            char_idx_q  <= char_idx_d;
            line_sel_q  <= line_sel_d;
            data_q      <= data_d;
            got_q       <= got_d;
            underrun_q  <= underrun_d;
            init_done_q <= init_done_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        slot_cnt_d  = slot_cnt_q;
        char_idx_d  = char_idx_q;
        line_sel_d  = line_sel_q;
        data_d      = data_q;
        got_d       = got_q;
        underrun_d  = underrun_q;
        init_done_d = init_done_q;

        slot_end = (sc_q == SC_LAST);
        sc_d     = slot_end ? '0 : sc_q + 1'b1;
        is_char  = (state_q == L1_CHAR) || (state_q == L2_CHAR);
        is_idle  = (state_q == PWR_DELAY) || (state_q == CLR_WAIT);

        case (state_q)
            FUNC_SET: cmd_byte = 8'h38;
            DISP_ON:  cmd_byte = CMD_DISP_ON;
            ENTRY:    cmd_byte = 8'h06;
            CLEAR:    cmd_byte = 8'h01;
            L1_ADDR:  cmd_byte = 8'h80;
            L2_ADDR:  cmd_byte = 8'hC0;
            default:  cmd_byte = 8'h00;
        endcase

        // Command byte goes onto the bus one cycle into the slot.
        if (!is_idle && !is_char && sc_q == '0) begin
            data_d = cmd_byte;
        end

        // Character latch window covers slot cycles 0..E_ON-1. Only the first
        // valid byte in the window is kept. If no byte has arrived one cycle
        // before the window closes, the bus is preloaded with a space so the
        // setup time before E holds either way.
        if (is_char) begin
            if (sc_q == '0) begin
                got_d = char_valid_i;
                if (char_valid_i) begin
                    data_d = char_data_i;
                end
            end else if (sc_q <= SC_LATCH_END) begin
                if (!got_q && char_valid_i) begin
                    got_d  = 1'b1;
                    data_d = char_data_i;
                end else if (!got_q && sc_q == SC_PRE) begin
                    data_d = 8'h20;
                end else if (!got_q && sc_q == SC_LATCH_END) begin
                    underrun_d = 1'b1;
                end
            end
        end

        if (slot_end) begin
            case (state_q)
                PWR_DELAY: begin
                    if (slot_cnt_q == PWR_LAST) begin
                        slot_cnt_d = '0;
                        state_d    = FUNC_SET;
                    end else begin
                        slot_cnt_d = slot_cnt_q + 1'b1;
                    end
                end
                FUNC_SET: state_d = DISP_ON;
                DISP_ON:  state_d = ENTRY;
                ENTRY:    state_d = CLEAR;
                CLEAR:    state_d = CLR_WAIT;
                CLR_WAIT: begin
                    if (slot_cnt_q == CLR_LAST) begin
                        slot_cnt_d  = '0;
                        state_d     = L1_ADDR;
                        init_done_d = 1'b1;
                        line_sel_d  = 1'b0;
                        char_idx_d  = '0;
                    end else begin
                        slot_cnt_d = slot_cnt_q + 1'b1;
                    end
                end
                L1_ADDR:  state_d = L1_CHAR;
                L1_CHAR: begin
                    char_idx_d = char_idx_q + 1'b1;
                    if (char_idx_q == 4'd15) begin
                        state_d    = L2_ADDR;
                        line_sel_d = 1'b1;
                    end
                end
                L2_ADDR:  state_d = L2_CHAR;
                L2_CHAR: begin
                    char_idx_d = char_idx_q + 1'b1;
                    if (char_idx_q == 4'd15) begin
                        state_d    = L1_ADDR;
                        line_sel_d = 1'b0;
                    end
                end
                default:  state_d = PWR_DELAY;
            endcase
        end
    end

    // A byte arriving on the last cycle of the latch window is forwarded to
    // the bus straight away, so the bus already shows the final value at
    // E_ON-1 and does not change when E rises.
    assign lcd_data_o  = (is_char && sc_q == SC_LATCH_END && !got_q && char_valid_i)
                         ? char_data_i : data_q;
    assign lcd_e_o     = !is_idle && (sc_q >= SC_E_ON) && (sc_q <= SC_E_OFF);
    assign lcd_rs_o    = is_char;
    assign lcd_rw_o    = 1'b0;
    assign char_req_o  = is_char && (sc_q == '0);
    assign line_sel_o  = line_sel_q;
    assign char_idx_o  = char_idx_q;
    assign init_done_o = init_done_q;
    assign underrun_o  = underrun_q;

endmodule

// File: tb/tb_lcd_text_driver.sv
module tb_lcd_text_driver;

    logic       clk = 1'b0;
    logic       resetn;
    logic [7:0] char_data;
    logic       char_valid;
    logic       char_req;
    logic       line_sel;
    logic [3:0] char_idx;
    logic       lcd_e;
    logic       lcd_rs;
    logic       lcd_rw;
    logic [7:0] lcd_data;
    logic       init_done;
    logic       underrun;

    always #5 clk = ~clk;

    lcd_text_driver dut (
        .clk_i        (clk),
        .resetn_i     (resetn),
        .char_data_i  (char_data),
        .char_valid_i (char_valid),
        .char_req_o   (char_req),
        .line_sel_o   (line_sel),
        .char_idx_o   (char_idx),
        .lcd_e_o      (lcd_e),
        .lcd_rs_o     (lcd_rs),
        .lcd_rw_o     (lcd_rw),
        .lcd_data_o   (lcd_data),
        .init_done_o  (init_done),
        .underrun_o   (underrun)
    );

`ifdef LCD_CURSOR_BLINK_EN
    localparam logic [7:0] EXP_DISP = 8'h0F;
`else
    localparam logic [7:0] EXP_DISP = 8'h0C;
`endif

    // Expected LCD bus writes, {rs, data}, in bus order.
    logic [8:0] sb[$];

    int n_checks = 0;
    int n_fail   = 0;

    int   cyc = 0;
    int   rel_cyc = 0;
    int   clear_cyc = 0;
    bit   first_rise_pending = 0;
    bit   clear_seen = 0;
    int   l1_addr_after_clear = 0;
    bit   exp_underrun = 0;
    bit   exp_line = 0;
    logic [3:0] exp_idx = 4'd0;
    int   l1_pass = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic release_reset();
        sb.push_back({1'b0, 8'h38});
        sb.push_back({1'b0, EXP_DISP});
        sb.push_back({1'b0, 8'h06});
        sb.push_back({1'b0, 8'h01});
        sb.push_back({1'b0, 8'h80});
        rel_cyc            = cyc;
        first_rise_pending = 1;
        resetn             = 1'b1;
    endtask

    // Monitor: one bus write per E rising edge.
    initial begin : monitor
        logic       e_prev;
        logic [8:0] rise_val;
        logic [8:0] last_high;
        logic [8:0] exp;
        e_prev    = 1'b0;
        rise_val  = '0;
        last_high = '0;
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            if (resetn === 1'b1 && lcd_e === 1'b1 && !e_prev) begin
                rise_val = {lcd_rs, lcd_data};
                if (sb.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL lcd_byte: got 0x%0h with no write expected", rise_val);
                end else begin
                    exp = sb.pop_front();
                    check("lcd_byte", 32'(rise_val), 32'(exp));
                    if (exp == {1'b0, 8'h01}) begin
                        check("init_done_at_clear", 32'(init_done), 32'd0);
                        clear_cyc  = cyc;
                        clear_seen = 1;
                    end
                    if (exp == {1'b0, 8'h80}) begin
                        check("init_done_at_l1_addr", 32'(init_done), 32'd1);
                        if (clear_seen) begin
                            check("clr_wait_clocks", 32'(cyc - clear_cyc), 32'd2050);
                            clear_seen = 0;
                            l1_addr_after_clear++;
                        end
                    end
                end
                if (first_rise_pending) begin
                    check("poweron_clocks_to_first_e", 32'(cyc - rel_cyc), 32'd3510);
                    first_rise_pending = 0;
                end
                check("lcd_rw", 32'(lcd_rw), 32'd0);
                check("underrun", 32'(underrun), 32'(exp_underrun));
            end
            if (lcd_e === 1'b1) last_high = {lcd_rs, lcd_data};
            if (resetn === 1'b1 && lcd_e === 1'b0 && e_prev)
                check("bus_stable_while_e", 32'(last_high), 32'(rise_val));
            e_prev = (lcd_e === 1'b1);
        end
    end

    // Character source: answers each request and records the expected write.
    initial begin : source
        logic [7:0] b;
        int         mode;
        forever begin
            @(posedge clk);
            #1;
            if (resetn === 1'b1 && char_req === 1'b1) begin
                check("line_sel", 32'(line_sel), 32'(exp_line));
                check("char_idx", 32'(char_idx), 32'(exp_idx));
                if (!exp_line && exp_idx == 4'd0) l1_pass++;
                case (exp_idx)
                    4'd0:    b = 8'h43;
                    4'd1:    b = 8'h6F;
                    4'd2:    b = 8'h6E;
                    default: b = 8'h65;
                endcase
                mode = 0;
                if (l1_pass == 2 && !exp_line) begin
                    if (exp_idx == 4'd5) mode = 1;
                    if (exp_idx == 4'd7) mode = 2;
                    if (exp_idx == 4'd9) mode = 3;
                end
                case (mode)
                    1: begin sb.push_back({1'b1, 8'h20}); exp_underrun = 1; end
                    2:       sb.push_back({1'b1, 8'h20});
                    3:       sb.push_back({1'b1, 8'h41});
                    default: sb.push_back({1'b1, b});
                endcase
                if (exp_idx == 4'd15) begin
                    sb.push_back({1'b0, exp_line ? 8'h80 : 8'hC0});
                    exp_line = ~exp_line;
                end
                exp_idx = exp_idx + 4'd1;
                if (mode == 0) begin
                    repeat (2) @(posedge clk);
                    #1; char_valid = 1'b1; char_data = b;
                    @(posedge clk);
                    #1; char_valid = 1'b0;
                end else if (mode == 2) begin
                    repeat (10) @(posedge clk);
                    #1; char_valid = 1'b1; char_data = b;
                    @(posedge clk);
                    #1; char_valid = 1'b0;
                end else if (mode == 3) begin
                    repeat (2) @(posedge clk);
                    #1; char_valid = 1'b1; char_data = 8'h41;
                    @(posedge clk);
                    #1; char_valid = 1'b0;
                    @(posedge clk);
                    #1; char_valid = 1'b1; char_data = 8'h42;
                    @(posedge clk);
                    #1; char_valid = 1'b0;
                end
            end
        end
    end

    initial begin : main
        bit hit;
        resetn     = 1'b0;
        char_valid = 1'b0;
        char_data  = 8'h00;
        repeat (5) @(posedge clk);
        #1;
        check("rst_char_req",  32'(char_req),  32'd0);
        check("rst_line_sel",  32'(line_sel),  32'd0);
        check("rst_char_idx",  32'(char_idx),  32'd0);
        check("rst_lcd_e",     32'(lcd_e),     32'd0);
        check("rst_lcd_rs",    32'(lcd_rs),    32'd0);
        check("rst_lcd_rw",    32'(lcd_rw),    32'd0);
        check("rst_lcd_data",  32'(lcd_data),  32'd0);
        check("rst_init_done", 32'(init_done), 32'd0);
        check("rst_underrun",  32'(underrun),  32'd0);
        @(negedge clk);
        release_reset();

        // Third pass of line 1: reset while E is high on column 3.
        hit = 0;
        for (int i = 0; i < 30000; i++) begin
            @(posedge clk);
            #2;
            if (l1_pass == 3 && char_idx == 4'd3 && lcd_e === 1'b1) begin
                hit = 1;
                break;
            end
        end
        if (!hit) begin
            n_checks++;
            n_fail++;
            $display("FAIL reset_point_timeout: got no E on pass 3 col 3, required within 30000 clk");
        end
        resetn = 1'b0;
        @(posedge clk);
        #1;
        check("midreset_lcd_e",     32'(lcd_e),     32'd0);
        check("midreset_init_done", 32'(init_done), 32'd0);
        check("midreset_underrun",  32'(underrun),  32'd0);
        check("midreset_lcd_data",  32'(lcd_data),  32'd0);
        check("midreset_line_sel",  32'(line_sel),  32'd0);
        sb.delete();
        exp_underrun = 0;
        exp_line     = 0;
        exp_idx      = 4'd0;
        clear_seen   = 0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        release_reset();

        hit = 0;
        for (int i = 0; i < 12000; i++) begin
            @(posedge clk);
            #3;
            if (l1_addr_after_clear >= 2) begin
                hit = 1;
                break;
            end
        end
        if (!hit) begin
            n_checks++;
            n_fail++;
            $display("FAIL reinit_timeout: got %0d line-1 address writes after clear, required 2", l1_addr_after_clear);
        end
        repeat (60) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
